// File: rtl/output_serializer.sv
// output_serializer: captures one packed MAC result vector in a single cycle and
// streams it out one rescaled, narrowed element per cycle over valid/ready with a
// last-element marker.
// Build option: define OUTPUT_SERIALIZER_SATURATE_EN to clamp narrowed elements
// to the OUT_W signed range; otherwise they are truncated (two's-complement wrap).
module output_serializer #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned N_OUT = 32,
    parameter int unsigned SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_OUT*ACC_W-1:0]   outvec_bus,
    input  logic                     outvec_valid,
    output logic                     outvec_ready,
    output logic                     busy,
    output logic signed [OUT_W-1:0]  data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic                     data_out_last
);

    localparam int unsigned PTR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_OUT - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                  state_q, state_d;
    logic [N_OUT*ACC_W-1:0]  vec_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        next_ptr;
    logic signed [OUT_W-1:0] data_q;
    logic                    valid_q;
    logic                    last_q;
    logic                    capture;
    logic                    xfer;
    logic                    final_xfer;
    logic [ACC_W-1:0]        next_elem;

    // Rescale by SHIFT (sign-preserving), then narrow to OUT_W.
    function automatic logic signed [OUT_W-1:0] conv(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] y;
        y = x >>> SHIFT;
`ifdef OUTPUT_SERIALIZER_SATURATE_EN
        // In range iff all bits from the OUT_W sign bit upward agree.
        if ((y[ACC_W-1:OUT_W-1] == '0) || (y[ACC_W-1:OUT_W-1] == '1)) begin
            conv = OUT_W'(y);
        end else if (y[ACC_W-1]) begin
            conv = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            conv = {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        conv = OUT_W'(y);
`endif
    endfunction

    assign capture    = (state_q == StIdle) && outvec_valid;
    assign xfer       = (state_q == StStream) && valid_q && data_out_ready;
    assign final_xfer = xfer && (rd_ptr_q == LAST_PTR);
    // Clamp to 0 at the last element so the element select never runs off the end.
    assign next_ptr   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    assign next_elem  = vec_q[32'(next_ptr) * ACC_W +: ACC_W];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture moves to streaming, final transfer returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (capture)    state_d = StStream;
            StStream: if (final_xfer) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded straight from state.
    always_comb begin
        outvec_ready = (state_q == StIdle);
        busy         = (state_q != StIdle);
    end

    // Vector register, read pointer and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q    <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else if (capture) begin
            vec_q    <= outvec_bus;
            rd_ptr_q <= '0;
            data_q   <= conv(outvec_bus[ACC_W-1:0]);
            valid_q  <= 1'b1;
            last_q   <= (N_OUT == 1);
        end else if (xfer) begin
            if (rd_ptr_q == LAST_PTR) begin
                rd_ptr_q <= '0;
                valid_q  <= 1'b0;
                last_q   <= 1'b0;
            end else begin
                rd_ptr_q <= next_ptr;
                data_q   <= conv(next_elem);
                last_q   <= (next_ptr == LAST_PTR);
            end
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign data_out_last  = last_q;

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: a 4-element SHIFT=0 instance and a
// 1-element SHIFT=8 instance, each with a scoreboard fed at vector send time and
// drained at every observed output transfer.
module tb_output_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: N_OUT=4, SHIFT=0
    logic [127:0]       bus_a;
    logic               ov_a, rdy_a, busy_a, va, la, ra;
    logic signed [15:0] da;
    // Instance B: N_OUT=1, SHIFT=8
    logic [31:0]        bus_b;
    logic               ov_b, rdy_b, busy_b, vb, lb, rb;
    logic signed [15:0] db;

    output_serializer #(.ACC_W(32), .OUT_W(16), .N_OUT(4), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .outvec_bus(bus_a), .outvec_valid(ov_a),
        .outvec_ready(rdy_a), .busy(busy_a), .data_out(da), .data_out_valid(va),
        .data_out_ready(ra), .data_out_last(la)
    );

    output_serializer #(.ACC_W(32), .OUT_W(16), .N_OUT(1), .SHIFT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .outvec_bus(bus_b), .outvec_valid(ov_b),
        .outvec_ready(rdy_b), .busy(busy_b), .data_out(db), .data_out_valid(vb),
        .data_out_ready(rb), .data_out_last(lb)
    );

    typedef struct {
        longint data;
        logic   last;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_vec = 0;
    int   n_err = 0;
    int   xfer_a = 0;
    int   base;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference rescale + narrow to 16 bits.
    function automatic longint model(input longint x, input int sh);
        longint y;
        y = x >>> sh;
`ifdef OUTPUT_SERIALIZER_SATURATE_EN
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
`else
        y = y & 64'hFFFF;
        if (y >= 32768) y = y - 65536;
`endif
        return y;
    endfunction

    // Scoreboard drain for instance A: a transfer happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n && va && ra) begin
            xfer_a++;
            check("a_has_exp", longint'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                check("a_data", longint'(da), ea.data);
                check("a_last", longint'(la), longint'(ea.last));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && vb && rb) begin
            check("b_has_exp", longint'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                check("b_data", longint'(db), eb.data);
                check("b_last", longint'(lb), longint'(eb.last));
            end
        end
    end

    // Present one vector to A for one cycle; returns one cycle after capture.
    task automatic send_a(input int e0, input int e1, input int e2, input int e3);
        int el[4];
        el = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            bus_a[k*32 +: 32] = el[k];
            q_a.push_back('{data: model(longint'(el[k]), 0), last: (k == 3)});
        end
        ov_a = 1'b1;
        @(posedge clk); #1;
        ov_a = 1'b0;
    endtask

    task automatic send_b(input int e);
        bus_b = e;
        q_b.push_back('{data: model(longint'(e), 8), last: 1'b1});
        ov_b = 1'b1;
        @(posedge clk); #1;
        ov_b = 1'b0;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 100 && !rdy_a; i++) begin
            @(posedge clk); #1;
        end
        check("a_idle_timeout", longint'(rdy_a), 1);
    endtask

    task automatic wait_idle_b();
        for (int i = 0; i < 100 && !rdy_b; i++) begin
            @(posedge clk); #1;
        end
        check("b_idle_timeout", longint'(rdy_b), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp1[4];
        exp1 = '{1, -2, 3, -4};
        rst_n = 1'b0;
        bus_a = '0; ov_a = 1'b0; ra = 1'b1;
        bus_b = '0; ov_b = 1'b0; rb = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", longint'(va), 0);
        check("rst_last", longint'(la), 0);
        check("rst_data", longint'(da), 0);
        check("rst_ready", longint'(rdy_a), 1);
        check("rst_busy", longint'(busy_a), 0);
        rst_n = 1'b1;

        // Basic stream with continuous ready.
        send_a(1, -2, 3, -4);
        check("t1_first_valid", longint'(va), 1);
        check("t1_busy", longint'(busy_a), 1);
        for (int k = 0; k < 4; k++) begin
            check("t1_data", longint'(da), longint'(exp1[k]));
            check("t1_last", longint'(la), longint'(k == 3));
            @(posedge clk); #1;
        end
        check("t1_ready_back", longint'(rdy_a), 1);
        check("t1_valid_low", longint'(va), 0);

        // Backpressure while element 1 is presented.
        base = xfer_a;
        send_a(10, 20, 30, 40);
        @(posedge clk); #1;
        ra = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_data_hold", longint'(da), 20);
            check("bp_valid_hold", longint'(va), 1);
            check("bp_last_hold", longint'(la), 0);
        end
        ra = 1'b1;
        wait_idle_a();
        check("bp_xfer_count", longint'(xfer_a - base), 4);

        // A second vector offered mid-stream is ignored.
        send_a(5, 6, 7, 8);
        bus_a = {4{32'd99}};
        ov_a = 1'b1;
        @(posedge clk); #1;
        ov_a = 1'b0;
        check("ign_busy", longint'(busy_a), 1);
        check("ign_ready", longint'(rdy_a), 0);
        check("ign_data", longint'(da), 6);
        wait_idle_a();

        // Overflow handling on narrowing.
        send_a(40000, -40000, 32767, -32768);
        wait_idle_a();

        // SHIFT=8 single-element instance.
        send_b(32'h0001_2300);
        check("b_first_valid", longint'(vb), 1);
        check("b_single_last", longint'(lb), 1);
        check("b_shift_data", longint'(db), 16'sh0123);
        wait_idle_b();
        send_b(32'hFFFF_FF00);
        check("b_neg_one", longint'(db), -1);
        wait_idle_b();
        send_b(40000 * 256);
        wait_idle_b();
        send_b(-40000 * 256);
        wait_idle_b();

        // Reset mid-stream after element 1 is presented.
        send_a(11, 12, 13, 14);
        @(posedge clk); #1;
        check("mr_elem1", longint'(da), 12);
        rst_n = 1'b0;
        q_a.delete();
        @(posedge clk); #1;
        check("mr_valid", longint'(va), 0);
        check("mr_ready", longint'(rdy_a), 1);
        rst_n = 1'b1;
        send_a(21, 22, 23, 24);
        check("mr_restart", longint'(da), 21);
        wait_idle_a();
        repeat (3) @(posedge clk);
        #1;

        check("a_queue_drained", longint'(q_a.size()), 0);
        check("b_queue_drained", longint'(q_b.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Counterpart to the MAC-side input buffer: accepts one packed result vector from the MAC and streams it out one element per cycle.
- The MAC presents the whole vector in a single cycle.
- Each accumulator element is rescaled (arithmetic shift) and narrowed to the output width before transmission.
- The stream interface uses a valid/ready handshake with a last-element marker; it feeds the next layer's input stream or the host.

Parameters:
- ACC_W, 32, width of each MAC accumulator element in the packed bus
- OUT_W, 16, width of each streamed output element
- N_OUT, 32, number of elements per result vector
- SHIFT, 8, arithmetic right-shift applied to each element before narrowing (0 ≤ SHIFT < ACC_W)

Ports:
- clk, in, 1, clock
- rst_n, in, 1, reset; synchronous, active-low
- outvec_bus, in, N_OUT*ACC_W, packed signed results; element k is at bits [(k+1)*ACC_W-1 -: ACC_W]
- outvec_valid, in, 1, outvec_bus valid this cycle
- outvec_ready, out, 1, block can capture a vector this cycle
- busy, out, 1, equals !outvec_ready; MAC stall indication
- data_out, out, OUT_W, signed streamed element
- data_out_valid, out, 1, data_out valid
- data_out_ready, in, 1, downstream accepts data_out
- data_out_last, out, 1, high with the final element (index N_OUT-1)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, rd_ptr = 0, vector register cleared.
  - data_out = 0, data_out_valid = 0, data_out_last = 0, outvec_ready = 1, busy = 0.
  - Reset mid-stream discards the remaining elements; nothing is re-sent afterwards.
- States: IDLE, STREAM.
- IDLE:
  - outvec_ready = 1.
  - On outvec_valid, the full bus is registered internally, rd_ptr = 0, and state → STREAM.
  - Next cycle: data_out_valid = 1, data_out = conv(element 0). Capture-to-first-valid latency is 1 cycle.
- STREAM:
  - outvec_ready = 0. outvec_valid is ignored, and the vector register does not change.
  - A transfer completes on a cycle where data_out_valid & data_out_ready.
  - While data_out_ready = 0, data_out, data_out_valid and data_out_last hold stable.
  - After a transfer of element k < N_OUT-1: the next cycle presents element k+1, so one element per cycle under continuous ready.
  - data_out_last = 1 exactly while element N_OUT-1 is presented.
  - On transfer of the last element: data_out_valid = 0, data_out_last = 0, rd_ptr = 0, state → IDLE; outvec_ready = 1 on the following cycle.
  - Minimum period between captures = N_OUT+1 cycles.
- data_out and data_out_last are registered outputs. outvec_ready and busy decode directly from state.
- conv(x):
  - y = x >>> SHIFT (arithmetic shift, sign-preserving).
  - Narrowing to OUT_W is defined under Optional Feature.
- N_OUT = 1: the single element is presented with data_out_last = 1.
- rd_ptr width = max(1, clog2(N_OUT)). rd_ptr never exceeds N_OUT-1.
- If outvec_valid and a final-element transfer occur in the same cycle, the vector is NOT captured (outvec_ready = 0 that cycle). The MAC must hold or retry.

Optional Feature:
- Macro: OUTPUT_SERIALIZER_SATURATE_EN.
- Defined: y is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Example with OUT_W = 16: y = 40000 → 32767; y = -40000 → -32768.
- Undefined: plain truncation to the low OUT_W bits of y (two's-complement wrap).
  - Example: y = 40000 → -25536.
- Either mode: in-range values pass unchanged.

Test Plan:
- Reset, then one vector with N_OUT = 4, SHIFT = 0, elements {1, -2, 3, -4}, data_out_ready held 1:
  - data_out_valid rises 1 cycle after capture.
  - Outputs are 1, -2, 3, -4 on consecutive cycles; last = 1 only with -4.
  - outvec_ready returns 1 one cycle after the last transfer.
- Backpressure:
  - Drop data_out_ready for 3 cycles while element 1 is presented → data_out stays at element 1, valid stays 1, no element skipped or duplicated.
  - Total of 4 transfers.
- Second vector: pulse outvec_valid with new data while streaming → ignored; the stream continues with the original data and busy = 1.
- SHIFT = 8, element 0x0001_2300 → data_out = 0x0123. Element 0xFFFF_FF00 → data_out = -1.
- Overflow, SHIFT = 0, element 40000:
  - With OUTPUT_SERIALIZER_SATURATE_EN → 32767.
  - Without → -25536.
  - Repeat with -40000 → -32768 / 25536.
- Assert rst_n low mid-stream after element 1 → next cycle data_out_valid = 0, outvec_ready = 1. A new vector then streams from element 0.
